// File: rtl/fyra_pkg.sv
// Shared types and helpers for the register writeback path: load funct3
// encodings, load-queue entry layout and load data extraction/extension.
package fyra_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    LD_B  = 3'b000,
    LD_H  = 3'b001,
    LD_W  = 3'b010,
    LD_BU = 3'b100,
    LD_HU = 3'b101
  } ld_funct3_e;

  typedef struct packed {
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [1:0]      addr_lo;
    logic [XLEN-1:0] data;
  } ld_entry_t;

  function automatic logic ld_supported(input logic [2:0] funct3);
    logic ok_v;
    case (funct3)
      LD_B, LD_H, LD_W, LD_BU, LD_HU: ok_v = 1'b1;
      default:                        ok_v = 1'b0;
    endcase
    return ok_v;
  endfunction

  // Halfword select uses addr_lo[1] only; unsupported encodings yield zero.
  function automatic logic [XLEN-1:0] ld_format(input logic [2:0]      funct3,
                                                input logic [1:0]      addr_lo,
                                                input logic [XLEN-1:0] data);
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic [XLEN-1:0] res_v;
    byte_v = data[{addr_lo, 3'b000} +: 8];
    half_v = data[{addr_lo[1], 4'b0000} +: 16];
    case (funct3)
      LD_B:    res_v = {{24{byte_v[7]}}, byte_v};
      LD_H:    res_v = {{16{half_v[15]}}, half_v};
      LD_W:    res_v = data;
      LD_BU:   res_v = {24'd0, byte_v};
      LD_HU:   res_v = {16'd0, half_v};
      default: res_v = {XLEN{1'b0}};
    endcase
    return res_v;
  endfunction

  function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
    return 32'd1 << rd;
  endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// Two-entry shift-style load queue: ent0 is always the head, ent1 the
// second-oldest entry. Push is ignored when full, pop when empty.
module wb_load_fifo
  import fyra_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  ld_entry_t din,
  output logic [1:0] count,
  output ld_entry_t ent0,
  output ld_entry_t ent1
);

  logic [1:0] count_r;
  ld_entry_t  ent0_r;
  ld_entry_t  ent1_r;
  logic       push_s;
  logic       pop_s;

  assign push_s = push && (count_r != 2'd2);
  assign pop_s  = pop && (count_r != 2'd0);

  // Queue storage and occupancy; entries shift toward the head on pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= 2'd0;
      ent0_r  <= '0;
      ent1_r  <= '0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (count_r == 2'd0) ent0_r <= din;
          else                 ent1_r <= din;
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          ent0_r  <= ent1_r;
          count_r <= count_r - 2'd1;
        end
        2'b11: begin
          ent0_r <= din;
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  assign count = count_r;
  assign ent0  = ent0_r;
  assign ent1  = ent1_r;

endmodule

// File: rtl/reg_writeback.sv
// Register-file write port arbiter: merges ALU results and queued load
// returns onto one registered write slot and tracks pending load targets.
module reg_writeback
  import fyra_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LD_BURST   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  aluValid,
  input  logic [4:0]            aluRd,
  input  logic [DATA_WIDTH-1:0] aluData,
  output logic                  aluReady,
  input  logic                  ldValid,
  input  logic [4:0]            ldRd,
  input  logic [2:0]            ldFunct3,
  input  logic [1:0]            ldAddrLo,
  input  logic [DATA_WIDTH-1:0] ldData,
  output logic                  ldReady,
  output logic                  wrEn,
  output logic [4:0]            rd,
  output logic [DATA_WIDTH-1:0] dOut,
  output logic [31:0]           pendMask
);

  localparam int BW = $clog2(LD_BURST + 1);

  logic [1:0]            count_s;
  ld_entry_t             head_s;
  ld_entry_t             tail_s;
  ld_entry_t             din_s;
  logic                  ld_ready_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  alu_take_s;
  logic [BW-1:0]         burst_r;
  logic [BW-1:0]         burst_nxt_s;
  logic [31:0]           pend_nxt_s;
  logic [31:0]           pend_r;
  logic                  wr_en_r;
  logic [4:0]            rd_r;
  logic [DATA_WIDTH-1:0] dout_r;

  assign din_s      = '{rd: ldRd, funct3: ldFunct3, addr_lo: ldAddrLo, data: ldData};
  assign ld_ready_s = rst_n && (count_s != 2'd2);
  assign push_s     = ldValid && ld_ready_s;
  assign pop_s      = rst_n && (count_s != 2'd0) && (burst_r < BW'(LD_BURST));
  assign alu_take_s = rst_n && !pop_s && aluValid;

  wb_load_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .din   (din_s),
    .count (count_s),
    .ent0  (head_s),
    .ent1  (tail_s)
  );

  // Burst counter: counts load pops made while an ALU result is waiting.
  always_comb begin
    burst_nxt_s = burst_r;
    if (!aluValid) begin
      burst_nxt_s = '0;
    end else if (pop_s) begin
      burst_nxt_s = burst_r + BW'(1);
    end else if (alu_take_s) begin
      burst_nxt_s = '0;
    end else begin
      burst_nxt_s = burst_r;
    end
  end

  // Pending mask of the post-edge queue contents: survivors plus new push.
  always_comb begin
    pend_nxt_s = 32'd0;
    if (count_s == 2'd2) begin
      pend_nxt_s = pend_nxt_s | rd_onehot(tail_s.rd);
    end else begin
      pend_nxt_s = pend_nxt_s;
    end
    if ((count_s != 2'd0) && !pop_s) begin
      pend_nxt_s = pend_nxt_s | rd_onehot(head_s.rd);
    end else begin
      pend_nxt_s = pend_nxt_s;
    end
    if (push_s) begin
      pend_nxt_s = pend_nxt_s | rd_onehot(ldRd);
    end else begin
      pend_nxt_s = pend_nxt_s;
    end
    pend_nxt_s[0] = 1'b0;
  end

  // Write-port registers, burst counter and pending mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_r <= '0;
      pend_r  <= 32'd0;
      wr_en_r <= 1'b0;
      rd_r    <= 5'd0;
      dout_r  <= '0;
    end else begin
      burst_r <= burst_nxt_s;
      pend_r  <= pend_nxt_s;
      if (pop_s) begin
        wr_en_r <= (head_s.rd != 5'd0) && ld_supported(head_s.funct3);
        rd_r    <= head_s.rd;
        dout_r  <= (head_s.rd != 5'd0)
                   ? ld_format(head_s.funct3, head_s.addr_lo, head_s.data) : '0;
      end else if (alu_take_s) begin
        wr_en_r <= (aluRd != 5'd0);
        rd_r    <= aluRd;
        dout_r  <= (aluRd != 5'd0) ? aluData : '0;
      end else begin
        wr_en_r <= 1'b0;
      end
    end
  end

  assign aluReady = alu_take_s;
  assign ldReady  = ld_ready_s;
  assign wrEn     = wr_en_r;
  assign rd       = rd_r;
  assign dOut     = dout_r;
  assign pendMask = pend_r;

endmodule

// File: tb/tb_reg_writeback.sv
// Scoreboard bench for reg_writeback: expected writes are queued as stimulus
// is issued and a negedge monitor checks every asserted write.
module tb_reg_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        aluValid;
  logic [4:0]  aluRd;
  logic [31:0] aluData;
  logic        aluReady;
  logic        ldValid;
  logic [4:0]  ldRd;
  logic [2:0]  ldFunct3;
  logic [1:0]  ldAddrLo;
  logic [31:0] ldData;
  logic        ldReady;
  logic        wrEn;
  logic [4:0]  rd;
  logic [31:0] dOut;
  logic [31:0] pendMask;

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];

  reg_writeback #(.DATA_WIDTH(32), .LD_BURST(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .aluValid (aluValid),
    .aluRd    (aluRd),
    .aluData  (aluData),
    .aluReady (aluReady),
    .ldValid  (ldValid),
    .ldRd     (ldRd),
    .ldFunct3 (ldFunct3),
    .ldAddrLo (ldAddrLo),
    .ldData   (ldData),
    .ldReady  (ldReady),
    .wrEn     (wrEn),
    .rd       (rd),
    .dOut     (dOut),
    .pendMask (pendMask)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write the DUT presents must match the next expected write.
  always @(negedge clk) begin
    logic [36:0] e;
    if (rst_n === 1'b1 && wrEn === 1'b1) begin
      check("write_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("write_rd", {27'd0, rd}, {27'd0, e[36:32]});
        check("write_data", dOut, e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    aluValid = 1'b0; aluRd = 5'd0; aluData = 32'd0;
    ldValid = 1'b0; ldRd = 5'd0; ldFunct3 = 3'd0; ldAddrLo = 2'd0; ldData = 32'd0;
  endtask

  logic [2:0]  f_tab[6]  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b011};
  logic [1:0]  a_tab[6]  = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0};
  logic [31:0] x_tab[6]  = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF,
                             32'h0000_7F01, 32'h80FF_7F01, 32'h0000_0000};
  logic        s_tab[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic        ar_tab[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic        lr_tab[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [31:0] pm_tab[10] = '{32'h0, 32'h0000_0800, 32'h0000_1000, 32'h0000_2000,
                              32'h0000_2000, 32'h0000_2000, 32'h0000_8000,
                              32'h0001_8000, 32'h0001_0000, 32'h0};
  logic [4:0]  lrd_tab[6] = '{5'd11, 5'd12, 5'd13, 5'd13, 5'd15, 5'd16};

  initial begin
    int ai;
    int li;
    rst_n = 1'b0;
    idle_inputs();
    aluValid = 1'b1; aluRd = 5'd5; ldValid = 1'b1; ldRd = 5'd3;
    #12;
    check("rst_wren", {31'd0, wrEn}, 32'd0);
    check("rst_rd", {27'd0, rd}, 32'd0);
    check("rst_dout", dOut, 32'd0);
    check("rst_pend", pendMask, 32'd0);
    check("rst_alu_ready", {31'd0, aluReady}, 32'd0);
    check("rst_ld_ready", {31'd0, ldReady}, 32'd0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ALU write to x5, then an idle cycle that must hold rd/dOut.
    aluValid = 1'b1; aluRd = 5'd5; aluData = 32'hDEAD_BEEF;
    #1;
    check("alu_ready_empty", {31'd0, aluReady}, 32'd1);
    exp_q.push_back({5'd5, 32'hDEAD_BEEF});
    tick();
    idle_inputs();
    check("alu_wren", {31'd0, wrEn}, 32'd1);
    tick();
    check("idle_wren", {31'd0, wrEn}, 32'd0);
    check("idle_rd_hold", {27'd0, rd}, 32'd5);
    check("idle_dout_hold", dOut, 32'hDEAD_BEEF);

    // Reset mid-stream with a load queued: async clear, load discarded.
    aluValid = 1'b1; aluRd = 5'd6; aluData = 32'h1234_5678;
    ldValid = 1'b1; ldRd = 5'd9; ldFunct3 = 3'b010; ldData = 32'h0000_0055;
    exp_q.push_back({5'd6, 32'h1234_5678});
    tick();
    idle_inputs();
    check("pend_before_reset", pendMask, 32'h0000_0200);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_wren", {31'd0, wrEn}, 32'd0);
    check("async_rst_pend", pendMask, 32'd0);
    check("async_rst_dout", dOut, 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
    tick();
    check("discarded_pend", pendMask, 32'd0);

    // Load formatting of 0x80FF7F01 into x7.
    for (int i = 0; i < 6; i++) begin
      ldValid = 1'b1; ldRd = 5'd7; ldFunct3 = f_tab[i]; ldAddrLo = a_tab[i];
      ldData = 32'h80FF_7F01;
      #1;
      check("fmt_ld_ready", {31'd0, ldReady}, 32'd1);
      if (s_tab[i]) exp_q.push_back({5'd7, x_tab[i]});
      tick();
      idle_inputs();
      check("fmt_pend", pendMask, 32'h0000_0080);
      tick();
      check("fmt_pend_clear", pendMask, 32'd0);
      if (!s_tab[i]) begin
        check("unsup_wren", {31'd0, wrEn}, 32'd0);
        check("unsup_dout", dOut, 32'd0);
      end
    end

    // rd=0 from the ALU and from a load.
    aluValid = 1'b1; aluRd = 5'd0; aluData = 32'h0000_0123;
    #1;
    check("x0_alu_ready", {31'd0, aluReady}, 32'd1);
    tick();
    idle_inputs();
    check("x0_alu_wren", {31'd0, wrEn}, 32'd0);
    check("x0_alu_dout", dOut, 32'd0);
    ldValid = 1'b1; ldRd = 5'd0; ldFunct3 = 3'b010; ldData = 32'hCAFE_F00D;
    #1;
    check("x0_ld_ready", {31'd0, ldReady}, 32'd1);
    tick();
    idle_inputs();
    check("x0_ld_pend", pendMask, 32'd0);
    tick();
    check("x0_ld_wren", {31'd0, wrEn}, 32'd0);
    check("x0_ld_rd", {27'd0, rd}, 32'd0);
    check("x0_ld_dout", dOut, 32'd0);

    // Continuous loads with aluValid held high: A L L A L L A L L A.
    exp_q.push_back({5'd20, 32'hA000_0000});
    exp_q.push_back({lrd_tab[0], 32'hB000_0000});
    exp_q.push_back({lrd_tab[1], 32'hB000_0001});
    exp_q.push_back({5'd21, 32'hA000_0001});
    exp_q.push_back({lrd_tab[2], 32'hB000_0002});
    exp_q.push_back({lrd_tab[3], 32'hB000_0003});
    exp_q.push_back({5'd22, 32'hA000_0002});
    exp_q.push_back({lrd_tab[4], 32'hB000_0004});
    exp_q.push_back({lrd_tab[5], 32'hB000_0005});
    exp_q.push_back({5'd23, 32'hA000_0003});
    ai = 0;
    li = 0;
    for (int c = 0; c < 10; c++) begin
      aluValid = 1'b1; aluRd = 5'(20 + ai); aluData = 32'hA000_0000 + 32'(ai);
      ldValid = (li < 6);
      if (li < 6) begin
        ldRd = lrd_tab[li]; ldFunct3 = 3'b010; ldAddrLo = 2'd0;
        ldData = 32'hB000_0000 + 32'(li);
      end
      #1;
      check("burst_alu_ready", {31'd0, aluReady}, {31'd0, ar_tab[c]});
      check("burst_ld_ready", {31'd0, ldReady}, {31'd0, lr_tab[c]});
      check("burst_pend", pendMask, pm_tab[c]);
      if (aluReady) ai++;
      if (ldValid && ldReady) li++;
      tick();
    end
    idle_inputs();
    check("burst_alu_count", 32'(ai), 32'd4);
    check("burst_ld_count", 32'(li), 32'd6);
    tick();
    tick();
    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Writer side of the core's register-file write port. Accepts ALU results and memory load returns through valid/ready handshakes, buffers loads in a 2-entry queue, and extracts and extends load data per funct3 and byte offset. It arbitrates the two sources onto the single registered write port (`wrEn`/`rd`/`dOut`, wired to the register file's `wrEn`/`rd`/`dIn`). It also exports a pending-load destination mask for the hazard unit.

## Interface
- `DATA_WIDTH`, 32, datapath width; load formatting is defined only for 32.
- `LD_BURST`, 2, maximum consecutive load writes while an ALU result waits.
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `aluValid`  in  1  ALU result offered.
- `aluRd`  in  5  ALU destination register.
- `aluData`  in  DATA_WIDTH  ALU result.
- `aluReady`  out  1  ALU result consumed this edge.
- `ldValid`  in  1  load return offered.
- `ldRd`  in  5  load destination register.
- `ldFunct3`  in  3  load type.
- `ldAddrLo`  in  2  load address bits [1:0].
- `ldData`  in  DATA_WIDTH  raw aligned memory word.
- `ldReady`  out  1  queue can accept a load.
- `wrEn`  out  1  register write enable (registered).
- `rd`  out  5  write destination (registered).
- `dOut`  out  DATA_WIDTH  write data (registered).
- `pendMask`  out  32  bit i set while a queued load targets xi.

## Operation
- Load queue: 2 entries holding {rd, funct3, addrLo, raw data}. Raw data is stored; formatting happens at the queue head.
- `ldReady` = occupancy < 2, derived from registered occupancy. There is no push-through when full, even if a pop occurs the same cycle.
- Arbitration per cycle, selecting one source for the write slot:
  - Queue non-empty and burst counter < `LD_BURST`: pop the head. If `aluValid` is high, increment the counter.
  - Otherwise, if `aluValid` is high: take the ALU result (`aluReady`=1) and clear the counter.
  - Queue empty: `aluReady`=`aluValid`.
  - If the ALU slot is taken because the counter reached `LD_BURST`, the counter clears.
  - The counter also clears when `aluValid` is low.
- Load formatting, with byte select b = `ldAddrLo` and half select h = `ldAddrLo[1]`:
  - 000 LB: sign-extend byte b.
  - 001 LH: sign-extend half h.
  - 010 LW: whole word.
  - 100 LBU: zero-extend byte b.
  - 101 LHU: zero-extend half h.
  - `ldAddrLo[0]` is ignored for halfwords.
- Unsupported funct3 (011, 110, 111): the slot is consumed, `wrEn`=0, and `dOut` is 0.
- rd = 0 from either source: the slot is consumed, `wrEn`=0, `rd`=0, and `dOut` is 0.
- Idle cycle (nothing selected): `wrEn`=0; `rd` and `dOut` hold their previous values.
- `pendMask`: bitwise OR of one-hot(rd) over valid queue entries, excluding x0. It is registered and updates on the same edge as push and pop.

## Timing
- Reset (`rst_n` low, asynchronous): `wrEn`=0, `rd`=0, `dOut`=0, `pendMask`=0, queue empty, burst counter 0.
  - `aluReady`=0 and `ldReady`=0 while `rst_n` is low.
  - Queued loads are discarded on reset mid-operation.
- ALU latency: accepted at edge N → `wrEn`/`rd`/`dOut` valid in cycle N..N+1 → register file commits at edge N+1.
- Load latency: accepted at edge N → earliest pop at edge N+1 → register file commits at edge N+2.
- Throughput: one write per cycle. Peak sustained load acceptance is one per cycle when the ALU is idle.
- Simultaneous events:
  - Push and pop on the same edge at occupancy 1: occupancy stays 1, and `pendMask` reflects the new entry only.
  - Same rd in two queue entries: the bit stays set until both are popped.
- Queue order is strictly FIFO; load results are never reordered relative to each other.

## Structure
- Shared package `fyra_pkg` holds:
  - the load funct3 enum (`LD_B`, `LD_H`, `LD_W`, `LD_BU`, `LD_HU`);
  - the typedef of the queue entry struct;
  - function `ld_format(funct3, addrLo, data)`.
- One sub-module: `wb_load_fifo`, a 2-entry queue with count and entry outputs, used for head data and `pendMask` generation.
- Arbitration, burst counter and output registers live in the top module.

## Test plan
- Reset, then ALU x5=0xDEADBEEF → next cycle: `wrEn`=1, `rd`=5, `dOut`=0xDEADBEEF. Reassert `rst_n` mid-stream → `wrEn`=0 immediately.
- Load `ldData`=0x80FF7F01 at x7 for each funct3/addrLo:
  - LB off 3 → 0xFFFFFF80.
  - LBU off 1 → 0x0000007F.
  - LH off 2 → 0xFFFF80FF.
  - LHU off 0 → 0x00007F01.
  - LW → 0x80FF7F01.
  - funct3 011 → `wrEn`=0.
- Three back-to-back loads with the write port stalled by ALU contention:
  - `ldReady` drops after occupancy reaches 2.
  - `pendMask` bits match the queued rds.
  - Each bit clears on its pop.
- Continuous loads plus `aluValid` held high → write sequence L, L, A, L, L, A (`LD_BURST`=2). `aluReady` pulses once per three cycles.
- rd=0 from ALU and from a load → slot consumed, handshake completes, `wrEn` stays 0, and `pendMask` bit 0 is never set.
